// File: rtl/memblk_xlat_pkg.sv
// -----------------------------------------------------------------------------
// memblk_xlat_pkg
//   Shared geometry, types and small helpers for the translated tile memory
//   block. The line geometry (line width, RAM depth, virtual address width,
//   page size, extra tag width) lives here so that every file in the block
//   sees the same typedefs. Change the geometry here, not on the instances.
// -----------------------------------------------------------------------------
package memblk_xlat_pkg;

  localparam int LINE_W    = 528;  // 66 bytes per line
  localparam int LINE_AW   = 10;   // log2 of RAM depth in lines
  localparam int VA_W      = 27;   // virtual line-address width
  localparam int PAGE_BITS = 6;    // page offset bits
  localparam int XTRA_W    = 4;    // per-line extra tag bits

  localparam int PPN_W    = LINE_AW - PAGE_BITS;
  localparam int VPN_W    = VA_W - PAGE_BITS;
  localparam int RD_W     = LINE_W + XTRA_W + 1;  // {tag, owned, line}
  localparam int PA_OUT_W = LINE_AW + 4;          // {line, tile x, tile y}

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [LINE_AW-1:0] pline_t;
  typedef logic [VA_W-1:0]    va_t;
  typedef logic [VPN_W-1:0]   vpn_t;
  typedef logic [PPN_W-1:0]   ppn_t;
  typedef logic [XTRA_W-1:0]  xtra_t;

  // Per-line side state; packing order gives {tag, owned} directly.
  typedef struct packed {
    xtra_t tag;
    logic  owned;
  } ext_t;

  typedef struct packed {
    logic vld;
    vpn_t vpn;
    ppn_t ppn;
  } tlb_entry_t;

  // S0: captured requests.
  typedef struct packed {
    logic  vld;
    va_t   va;
    xtra_t xtra;
  } rd_req_t;

  typedef struct packed {
    logic  vld;
    va_t   va;
    line_t data;
  } wr_req_t;

  // S1: translated requests.
  typedef struct packed {
    logic   vld;
    logic   hit;
    pline_t pa;
    xtra_t  xtra;
  } rd_xlat_t;

  typedef struct packed {
    logic   vld;
    logic   hit;
    pline_t pa;
    line_t  data;
  } wr_xlat_t;

  function automatic vpn_t va_vpn(input va_t va);
    return va[VA_W-1:PAGE_BITS];
  endfunction

  function automatic pline_t phys_line(input ppn_t ppn, input va_t va);
    return {ppn, va[PAGE_BITS-1:0]};
  endfunction

endpackage

// File: rtl/memblk_xlat_tlb_cam.sv
// -----------------------------------------------------------------------------
// memblk_tlb_cam
//   Fully-associative translation table: ENTRIES registered entries with one
//   write port and NLOOKUP independent combinational lookup ports.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset (clears all entries)
//     i_we         write the entry at i_idx with i_entry this edge
//     i_idx        entry index
//     i_entry      {vld, vpn, ppn}
//     i_vpn        per-lookup virtual page number
//     o_hit        per-lookup hit
//     o_ppn        per-lookup physical page number (0 on miss)
// -----------------------------------------------------------------------------
module memblk_tlb_cam
  import memblk_xlat_pkg::*;
#(
  parameter  int ENTRIES = 8,   // power of two, >= 2
  parameter  int NLOOKUP = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_we,
  input  logic [IDX_W-1:0]                i_idx,
  input  tlb_entry_t                      i_entry,
  input  logic [NLOOKUP-1:0][VPN_W-1:0]   i_vpn,
  output logic [NLOOKUP-1:0]              o_hit,
  output logic [NLOOKUP-1:0][PPN_W-1:0]   o_ppn
);

  tlb_entry_t r_tlb [ENTRIES];

  // Lookups read the registered table, so an entry written at an edge is
  // only visible to lookups performed at later edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < ENTRIES; e++) r_tlb[e] <= '0;
    end else if (i_we) begin
      r_tlb[i_idx] <= i_entry;
    end
  end

  // Scan from the top entry down so the lowest matching index is the last
  // one written and therefore wins when several entries match.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // o_hit/o_ppn unassigned, which would otherwise infer latches.
    o_hit = '0;
    o_ppn = '0;
    for (int l = 0; l < NLOOKUP; l++) begin
      for (int e = ENTRIES - 1; e >= 0; e--) begin
        if (r_tlb[e].vld && (r_tlb[e].vpn == i_vpn[l])) begin
          o_hit[l] = 1'b1;
          o_ppn[l] = r_tlb[e].ppn;
        end
      end
    end
  end

endmodule

// File: rtl/memblk_xlat.sv
// -----------------------------------------------------------------------------
// memblk_xlat
//   Tile memory block with NPORTS read and NPORTS write ports sharing a
//   line-granular RAM. Every access is translated through a programmable
//   fully-associative TLB. Each line carries ext = {tag, owned}.
//
//   Pipeline (3 edges from accept to output):
//     E0  capture request into S0
//     E1  TLB lookup, S1 holds {hit, physical line}
//     E2  RAM / ext access, results registered onto the outputs
//   A TLB write (tlb_we) stalls the front end for that cycle: S0 holds, S1
//   is loaded with a bubble, S1 still drains to the outputs, and the entry
//   is written at that edge.
//
//   rd_valid marks a read hit; a translated miss raises rd_miss instead and
//   returns zero data and address. Write misses raise a one-cycle wr_miss.
//
//   Ports
//     clk, rst       clock, asynchronous active-low reset
//     random         free-running random value for the owned-drop decision
//     stall          inputs not accepted this cycle (= tlb_we)
//     rd_en/rd_addr/rd_xtra   read requests, VA and tag recorded on owned hit
//     rd_valid/rd_miss        read hit / read miss
//     rd_data        {tag, owned, line} as seen before this access' update
//     rd_pa          {physical line, TILE_X, TILE_Y}
//     wr_en/wr_addr/wr_data   write requests
//     wr_miss        write dropped on TLB miss
//     tlb_we/tlb_idx/tlb_vld/tlb_vpn/tlb_ppn   TLB entry write
// -----------------------------------------------------------------------------
module memblk_xlat
  import memblk_xlat_pkg::*;
#(
  parameter  int          NPORTS      = 4,
  parameter  int          TLB_ENTRIES = 8,
  parameter  logic [15:0] SHARE_MASK  = 16'h01ff,
  parameter  logic [15:0] SHARE_VAL   = 16'h0005,
  parameter  logic [1:0]  TILE_X      = 2'd0,
  parameter  logic [1:0]  TILE_Y      = 2'd0,
  localparam int          TLB_IDX_W   = $clog2(TLB_ENTRIES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  random,
  output logic                         stall,
  input  logic [NPORTS-1:0]            rd_en,
  input  logic [NPORTS*VA_W-1:0]       rd_addr,
  input  logic [NPORTS*XTRA_W-1:0]     rd_xtra,
  output logic [NPORTS-1:0]            rd_valid,
  output logic [NPORTS-1:0]            rd_miss,
  output logic [NPORTS*RD_W-1:0]       rd_data,
  output logic [NPORTS*PA_OUT_W-1:0]   rd_pa,
  input  logic [NPORTS-1:0]            wr_en,
  input  logic [NPORTS*VA_W-1:0]       wr_addr,
  input  logic [NPORTS*LINE_W-1:0]     wr_data,
  output logic [NPORTS-1:0]            wr_miss,
  input  logic                         tlb_we,
  input  logic [TLB_IDX_W-1:0]         tlb_idx,
  input  logic                         tlb_vld,
  input  logic [VPN_W-1:0]             tlb_vpn,
  input  logic [PPN_W-1:0]             tlb_ppn
);

  localparam int DEPTH = 1 << LINE_AW;
  localparam int NLOOK = 2 * NPORTS;  // reads first, then writes

  rd_req_t  r_rd_s0 [NPORTS];
  wr_req_t  r_wr_s0 [NPORTS];
  rd_xlat_t r_rd_s1 [NPORTS];
  wr_xlat_t r_wr_s1 [NPORTS];

  line_t r_ram [DEPTH];
  ext_t  r_ext [DEPTH];

  logic [NLOOK-1:0][VPN_W-1:0] w_vpn;
  logic [NLOOK-1:0]            w_hit;
  logic [NLOOK-1:0][PPN_W-1:0] w_ppn;
  tlb_entry_t                  w_tlb_wentry;
  logic                        w_share_drop;

  assign stall        = tlb_we;
  assign w_tlb_wentry = '{vld: tlb_vld, vpn: tlb_vpn, ppn: tlb_ppn};
  // One drop decision per cycle, shared by every owned read at this E2.
  assign w_share_drop = ((random & SHARE_MASK) == SHARE_VAL);

  always_comb begin
    w_vpn = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_vpn[p]          = va_vpn(r_rd_s0[p].va);
      w_vpn[NPORTS + p] = va_vpn(r_wr_s0[p].va);
    end
  end

  memblk_tlb_cam #(
    .ENTRIES (TLB_ENTRIES),
    .NLOOKUP (NLOOK)
  ) u_tlb (
    .clk     (clk),
    .rst_n   (rst),
    .i_we    (tlb_we),
    .i_idx   (tlb_idx),
    .i_entry (w_tlb_wentry),
    .i_vpn   (w_vpn),
    .o_hit   (w_hit),
    .o_ppn   (w_ppn)
  );

  // Front end: S0 capture and S1 translation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NPORTS; p++) begin
        r_rd_s0[p] <= '0;
        r_wr_s0[p] <= '0;
        r_rd_s1[p] <= '0;
        r_wr_s1[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (stall) begin
          // S0 keeps its request for the next edge; S1 gets a bubble.
          r_rd_s1[p] <= '0;
          r_wr_s1[p] <= '0;
        end else begin
          r_rd_s0[p] <= '{vld:  rd_en[p],
                          va:   rd_addr[p*VA_W +: VA_W],
                          xtra: rd_xtra[p*XTRA_W +: XTRA_W]};
          r_wr_s0[p] <= '{vld:  wr_en[p],
                          va:   wr_addr[p*VA_W +: VA_W],
                          data: wr_data[p*LINE_W +: LINE_W]};
          r_rd_s1[p] <= '{vld:  r_rd_s0[p].vld,
                          hit:  w_hit[p],
                          pa:   phys_line(w_ppn[p], r_rd_s0[p].va),
                          xtra: r_rd_s0[p].xtra};
          r_wr_s1[p] <= '{vld:  r_wr_s0[p].vld,
                          hit:  w_hit[NPORTS + p],
                          pa:   phys_line(w_ppn[NPORTS + p], r_wr_s0[p].va),
                          data: r_wr_s0[p].data};
        end
      end
    end
  end

  // Output stage: results of the S1 requests, sampled from the RAM and ext
  // state as it stands before this edge's updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= '0;
      rd_miss  <= '0;
      rd_data  <= '0;
      rd_pa    <= '0;
      wr_miss  <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        rd_valid[p] <= r_rd_s1[p].vld &  r_rd_s1[p].hit;
        rd_miss[p]  <= r_rd_s1[p].vld & ~r_rd_s1[p].hit;
        wr_miss[p]  <= r_wr_s1[p].vld & ~r_wr_s1[p].hit;
        if (r_rd_s1[p].vld && r_rd_s1[p].hit) begin
          rd_data[p*RD_W +: RD_W]         <= {r_ext[r_rd_s1[p].pa], r_ram[r_rd_s1[p].pa]};
          rd_pa[p*PA_OUT_W +: PA_OUT_W]   <= {r_rd_s1[p].pa, TILE_X, TILE_Y};
        end else begin
          rd_data[p*RD_W +: RD_W]         <= '0;
          rd_pa[p*PA_OUT_W +: PA_OUT_W]   <= '0;
        end
      end
    end
  end

  // NOTE: the line RAM and its ext bits are storage, not control state, so
  // they have no reset; a reset only flushes the pipeline and the TLB.
  always_ff @(posedge clk) begin
    // Owned reads first, ascending port order: the highest port's tag lands.
    for (int p = 0; p < NPORTS; p++) begin
      if (r_rd_s1[p].vld && r_rd_s1[p].hit && r_ext[r_rd_s1[p].pa].owned) begin
        r_ext[r_rd_s1[p].pa] <= '{tag: r_rd_s1[p].xtra, owned: ~w_share_drop};
      end
    end
    // Writes after reads so a colliding write's ext overrides a read's, and
    // again ascending so the highest write port wins.
    // NOTE: non-blocking assignments keep the output stage reading the
    // pre-update contents, giving read-before-write on same-line collisions.
    for (int p = 0; p < NPORTS; p++) begin
      if (r_wr_s1[p].vld && r_wr_s1[p].hit) begin
        r_ram[r_wr_s1[p].pa] <= r_wr_s1[p].data;
        r_ext[r_wr_s1[p].pa] <= '{tag: '0, owned: 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_memblk_xlat.sv
module tb_memblk_xlat;
  import memblk_xlat_pkg::*;

  localparam int NP = 4;

  localparam line_t DA = {66{8'hA5}};
  localparam line_t DB = {66{8'h3C}};
  localparam line_t DC = {66{8'h0F}};
  localparam line_t DD = {66{8'hD2}};
  localparam line_t DE = {66{8'h71}};

  logic                      clk = 1'b0;
  logic                      rst;
  logic [15:0]               random;
  logic                      stall;
  logic [NP-1:0]             rd_en, rd_valid, rd_miss, wr_en, wr_miss;
  logic [NP*VA_W-1:0]        rd_addr, wr_addr;
  logic [NP*XTRA_W-1:0]      rd_xtra;
  logic [NP*RD_W-1:0]        rd_data;
  logic [NP*PA_OUT_W-1:0]    rd_pa;
  logic [NP*LINE_W-1:0]      wr_data;
  logic                      tlb_we;
  logic [2:0]                tlb_idx;
  logic                      tlb_vld;
  vpn_t                      tlb_vpn;
  ppn_t                      tlb_ppn;

  int n_cmp = 0;
  int n_bad = 0;

  memblk_xlat dut (
    .clk      (clk),
    .rst      (rst),
    .random   (random),
    .stall    (stall),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_xtra  (rd_xtra),
    .rd_valid (rd_valid),
    .rd_miss  (rd_miss),
    .rd_data  (rd_data),
    .rd_pa    (rd_pa),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_miss  (wr_miss),
    .tlb_we   (tlb_we),
    .tlb_idx  (tlb_idx),
    .tlb_vld  (tlb_vld),
    .tlb_vpn  (tlb_vpn),
    .tlb_ppn  (tlb_ppn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [599:0] got, input logic [599:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en  = '0;
    wr_en  = '0;
    tlb_we = 1'b0;
  endtask

  task automatic rd(input int p, input va_t va, input xtra_t x);
    rd_en[p]                      = 1'b1;
    rd_addr[p*VA_W +: VA_W]       = va;
    rd_xtra[p*XTRA_W +: XTRA_W]   = x;
  endtask

  task automatic wr(input int p, input va_t va, input line_t d);
    wr_en[p]                      = 1'b1;
    wr_addr[p*VA_W +: VA_W]       = va;
    wr_data[p*LINE_W +: LINE_W]   = d;
  endtask

  // Accept the driven requests, then wait until their results are visible.
  task automatic launch();
    tick();
    idle();
    tick();
    tick();
  endtask

  task automatic tlb_prog(input logic [2:0] idx, input logic v, input vpn_t vpn, input ppn_t ppn);
    tlb_we  = 1'b1;
    tlb_idx = idx;
    tlb_vld = v;
    tlb_vpn = vpn;
    tlb_ppn = ppn;
    #1;
    check("stall_on_tlb_we", stall, 1'b1);
    tick();
    tlb_we = 1'b0;
  endtask

  function automatic logic [RD_W-1:0] rdat(input int p);
    return rd_data[p*RD_W +: RD_W];
  endfunction

  function automatic logic [PA_OUT_W-1:0] rpa(input int p);
    return rd_pa[p*PA_OUT_W +: PA_OUT_W];
  endfunction

  function automatic logic [RD_W-1:0] line_exp(input xtra_t tag, input logic owned, input line_t d);
    return {tag, owned, d};
  endfunction

  initial begin
    rst     = 1'b0;
    random  = 16'h0000;
    rd_addr = '0;
    rd_xtra = '0;
    wr_addr = '0;
    wr_data = '0;
    tlb_idx = '0;
    tlb_vld = 1'b0;
    tlb_vpn = '0;
    tlb_ppn = '0;
    idle();

    // Reset state.
    tick();
    tick();
    check("rst_rd_valid", rd_valid, 4'b0000);
    check("rst_rd_miss", rd_miss, 4'b0000);
    check("rst_wr_miss", wr_miss, 4'b0000);
    check("rst_rd_pa", rd_pa, '0);
    check("rst_stall", stall, 1'b0);
    for (int p = 0; p < NP; p++) check("rst_rd_data", rdat(p), '0);
    rst = 1'b1;
    tick();

    // TLB[0] maps vpn 5 -> ppn 3; write then read va 0x145 (pa 0x0C5).
    tlb_prog(3'd0, 1'b1, 21'h5, 4'h3);
    wr(0, 27'h145, DA);
    launch();
    check("wr_hit_no_miss", wr_miss, 4'b0000);
    rd(1, 27'h145, 4'h0);
    launch();
    check("rd_hit_valid", rd_valid, 4'b0010);
    check("rd_hit_miss", rd_miss, 4'b0000);
    check("rd_hit_data", rdat(1), line_exp(4'h0, 1'b1, DA));
    check("rd_hit_pa", rpa(1), 14'h0C50);

    // Miss handling, with line 0x0C0 seeded through va 0x140.
    wr(0, 27'h140, DE);
    launch();
    rd(0, 27'h1C0, 4'h0);
    launch();
    check("rd_miss_flag", rd_miss, 4'b0001);
    check("rd_miss_valid", rd_valid, 4'b0000);
    check("rd_miss_data", rdat(0), '0);
    check("rd_miss_pa", rpa(0), '0);
    wr(2, 27'h1C0, DB);
    launch();
    check("wr_miss_pulse", wr_miss, 4'b0100);
    tick();
    check("wr_miss_one_cycle", wr_miss, 4'b0000);
    // Map vpn 7 onto ppn 3: va 0x1C0 now reaches line 0x0C0, still DE.
    tlb_prog(3'd1, 1'b1, 21'h7, 4'h3);
    rd(3, 27'h1C0, 4'h0);
    launch();
    check("miss_wr_dropped", rdat(3), line_exp(4'h0, 1'b1, DE));
    check("new_entry_pa", rpa(3), 14'h0C00);
    // A second match at a higher index loses to entry 1.
    tlb_prog(3'd2, 1'b1, 21'h7, 4'h2);
    rd(3, 27'h1C0, 4'h0);
    launch();
    check("lowest_idx_pa", rpa(3), 14'h0C00);
    // Invalidating entry 1 exposes entry 2 (ppn 2 -> pa 0x080).
    tlb_prog(3'd1, 1'b0, 21'h7, 4'h3);
    rd(0, 27'h1C0, 4'h0);
    launch();
    check("invalid_entry_valid", rd_valid, 4'b0001);
    check("invalid_entry_pa", rpa(0), 14'h0800);

    // Read/write collision at the same E2.
    wr(0, 27'h145, DB);
    rd(2, 27'h145, 4'h7);
    launch();
    check("coll_rd_old", rdat(2), line_exp(4'h0, 1'b1, DA));
    rd(0, 27'h145, 4'h0);
    launch();
    check("coll_wr_wins", rdat(0), line_exp(4'h0, 1'b1, DB));

    // Two writes to one line: highest port wins.
    wr(0, 27'h145, DC);
    wr(3, 27'h145, DD);
    launch();
    rd(1, 27'h145, 4'h0);
    launch();
    check("multi_wr_hi_port", rdat(1), line_exp(4'h0, 1'b1, DD));

    // Owned read with a matching masked random clears owned.
    random = 16'hFE05;
    rd(1, 27'h145, 4'h9);
    launch();
    check("drop_rd_before", rdat(1), line_exp(4'h0, 1'b1, DD));
    random = 16'h0000;
    rd(1, 27'h145, 4'h3);
    launch();
    check("drop_rd_after", rdat(1), line_exp(4'h9, 1'b0, DD));
    rd(1, 27'h145, 4'h0);
    launch();
    check("shared_no_effect", rdat(1), line_exp(4'h9, 1'b0, DD));
    // Fresh line, non-matching random: owned stays set.
    wr(0, 27'h145, DA);
    launch();
    random = 16'h0006;
    rd(2, 27'h145, 4'h9);
    launch();
    check("keep_rd_before", rdat(2), line_exp(4'h0, 1'b1, DA));
    random = 16'h0000;
    rd(2, 27'h145, 4'h9);
    launch();
    check("keep_rd_after", rdat(2), line_exp(4'h9, 1'b1, DA));

    // Stall with requests in S1 (X, port 1) and S0 (Y, port 2); Z held.
    rd(1, 27'h145, 4'h9);
    tick();
    idle();
    rd(2, 27'h145, 4'h9);
    tick();
    idle();
    rd(3, 27'h400, 4'h9);
    tlb_we  = 1'b1;
    tlb_idx = 3'd3;
    tlb_vld = 1'b1;
    tlb_vpn = 21'h10;
    tlb_ppn = 4'h1;
    #1;
    check("stall_high", stall, 1'b1);
    tick();
    check("stall_s1_on_time", rd_valid, 4'b0010);
    check("stall_s1_data", rdat(1), line_exp(4'h9, 1'b1, DA));
    tlb_we = 1'b0;
    #1;
    check("stall_low", stall, 1'b0);
    tick();
    check("stall_bubble", rd_valid, 4'b0000);
    idle();
    tick();
    check("stall_s0_late", rd_valid, 4'b0100);
    check("stall_s0_data", rdat(2), line_exp(4'h9, 1'b1, DA));
    tick();
    check("stall_held_valid", rd_valid, 4'b1000);
    check("stall_held_pa", rpa(3), 14'h0400);
    tick();
    check("stall_drained", rd_valid, 4'b0000);

    // Reset mid-flight: one result visible, two more in S1/S0.
    rd(1, 27'h145, 4'h9);
    tick();
    idle();
    rd(2, 27'h145, 4'h9);
    tick();
    idle();
    rd(3, 27'h145, 4'h9);
    tick();
    idle();
    check("pre_rst_valid", rd_valid, 4'b0010);
    rst = 1'b0;
    #2;
    check("async_rst_valid", rd_valid, 4'b0000);
    check("async_rst_data", rdat(1), '0);
    check("async_rst_pa", rd_pa, '0);
    tick();
    check("rst_held_valid", rd_valid, 4'b0000);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("flushed_valid", rd_valid, 4'b0000);
      check("flushed_miss", rd_miss, 4'b0000);
    end
    // TLB is empty after reset: everything misses.
    rd(0, 27'h145, 4'h0);
    wr(1, 27'h145, DC);
    launch();
    check("post_rst_rd_miss", rd_miss, 4'b0001);
    check("post_rst_rd_valid", rd_valid, 4'b0000);
    check("post_rst_wr_miss", wr_miss, 4'b0010);
    check("post_rst_data", rdat(0), '0);
    check("post_rst_pa", rd_pa, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
